// File: rtl/eprobe_led_sequencer_pkg.sv
// Shared encodings and default field widths for the E-probe uLED address sequencer.
// Holds the FSM state and command mode enums plus a width helper.
package eprobe_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_PIX_W      = 2;
  localparam int DEF_ROW_W      = 6;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_LOAD_CYC   = 1;
  localparam int DEF_DWELL_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_NOP    = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_RANGE  = 2'b10,
    MODE_CONT   = 2'b11
  } mode_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eprobe_led_sequencer_if.sv
// Host-command / chip-pin bundle of the uLED sequencer.
// master = command source (host registers), slave = the sequencer itself.
interface eprobe_led_sequencer_if
  import eprobe_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int ROW_W   = DEF_ROW_W,
  parameter int DWELL_W = DEF_DWELL_W
);
  localparam int PROBE_W = ADDR_W - PIX_W - ROW_W;

  logic               trig;
  logic [1:0]         mode;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  end_addr;
  logic [ADDR_W-1:0]  stride;
  logic [DWELL_W-1:0] dwell;
  logic               abort;

  logic [PIX_W-1:0]   pix;
  logic [ROW_W-1:0]   addr;
  logic [PROBE_W-1:0] probe;
  logic               load;
  logic               busy;
  logic               done;
  logic [2:0]         state;

  modport master (
    output trig, mode, start_addr, end_addr, stride, dwell, abort,
    input  pix, addr, probe, load, busy, done, state
  );

  modport slave (
    input  trig, mode, start_addr, end_addr, stride, dwell, abort,
    output pix, addr, probe, load, busy, done, state
  );

endinterface

// File: rtl/eprobe_led_sequencer_addr_stepper.sv
// Combinational next-point calculator: next sweep address (with continuous wrap)
// and whether the current point is the final one of the command.
module eprobe_addr_stepper
  import eprobe_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  mode_e             mode,
  output logic [ADDR_W-1:0] nxt_addr,
  output logic              is_last
);

  logic [ADDR_W:0] sum;
  logic            past_end;

  // One extra bit so a step past the top of the address space is seen as the end.
  always_comb begin
    sum      = {1'b0, cur_addr} + {1'b0, stride};
    past_end = sum[ADDR_W] || (sum > {1'b0, end_addr});
    nxt_addr = sum[ADDR_W-1:0];
    is_last  = 1'b0;
    case (mode)
      MODE_SINGLE: is_last = 1'b1;
      MODE_RANGE:  is_last = past_end;
      MODE_CONT: begin
        if (past_end) begin
          nxt_addr = start_addr;
        end
      end
      default:     is_last = 1'b1;
    endcase
  end

endmodule

// File: rtl/eprobe_led_sequencer.sv
// uLED address sequencer: single / range / continuous sweeps with settle, load
// strobe and dwell timing, driving the probe/addr/pix fields and load pin.
module eprobe_led_sequencer
  import eprobe_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOAD_CYC   = DEF_LOAD_CYC,
  parameter int DWELL_W    = DEF_DWELL_W
) (
  input logic                   clk,
  input logic                   rst,
  eprobe_led_sequencer_if.slave bus
);

  localparam int CNT_W = max3($clog2(SETTLE_CYC + 1), $clog2(LOAD_CYC + 1), DWELL_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  mode_e              mode_q, mode_d;
  logic [ADDR_W-1:0]  start_q, start_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               cfg_load;
  logic [ADDR_W-1:0]  nxt_addr;
  logic               is_last;

  eprobe_addr_stepper #(.ADDR_W(ADDR_W)) u_stepper (
    .cur_addr   (cur_addr_q),
    .stride     (stride_q),
    .start_addr (start_q),
    .end_addr   (end_q),
    .mode       (mode_q),
    .nxt_addr   (nxt_addr),
    .is_last    (is_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    load_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_load   = 1'b0;

    // Abort wins over every other transition once a command is running.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          if (bus.trig && (bus.mode != MODE_NOP)) begin
            cfg_load   = 1'b1;
            cur_addr_d = bus.start_addr;
            state_d    = ST_SETTLE;
            cnt_d      = CNT_W'(SETTLE_CYC - 1);
            busy_d     = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_LOAD;
            load_d  = 1'b1;
            cnt_d   = CNT_W'(LOAD_CYC - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_LOAD: begin
          if (cnt_q != '0) begin
            load_d = 1'b1;
            cnt_d  = cnt_q - CNT_W'(1);
          end else if (is_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (dwell_q == '0) begin
            state_d    = ST_SETTLE;
            cur_addr_d = nxt_addr;
            cnt_d      = CNT_W'(SETTLE_CYC - 1);
          end else begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(dwell_q) - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d    = ST_SETTLE;
            cur_addr_d = nxt_addr;
            cnt_d      = CNT_W'(SETTLE_CYC - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Command parameters are captured once per accepted trigger; a zero stride means 1.
  always_comb begin
    mode_d   = mode_q;
    start_d  = start_q;
    end_d    = end_q;
    stride_d = stride_q;
    dwell_d  = dwell_q;
    if (cfg_load) begin
      mode_d   = mode_e'(bus.mode);
      start_d  = bus.start_addr;
      end_d    = bus.end_addr;
      stride_d = (bus.stride == '0) ? ADDR_W'(1) : bus.stride;
      dwell_d  = bus.dwell;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_addr_q <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_q   <= mode_d;
    start_q  <= start_d;
    end_q    <= end_d;
    stride_q <= stride_d;
    dwell_q  <= dwell_d;
  end

  assign bus.pix   = cur_addr_q[PIX_W-1:0];
  assign bus.addr  = cur_addr_q[PIX_W+ROW_W-1:PIX_W];
  assign bus.probe = cur_addr_q[ADDR_W-1:PIX_W+ROW_W];
  assign bus.load  = load_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_eprobe_led_sequencer.sv
// Self-checking bench for eprobe_led_sequencer: directed vector table, multi-cycle
// corner sequences and randomized sweeps against a point-list reference model.
module tb_eprobe_led_sequencer;
  import eprobe_pkg::*;

  localparam int ADDR_W     = 10;
  localparam int PIX_W      = 2;
  localparam int ROW_W      = 6;
  localparam int SETTLE_CYC = 8;
  localparam int LOAD_CYC   = 1;
  localparam int DWELL_W    = 16;
  localparam int PER_BASE   = SETTLE_CYC + LOAD_CYC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eprobe_led_sequencer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .ROW_W(ROW_W),
                            .DWELL_W(DWELL_W)) bus ();

  eprobe_led_sequencer #(
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .ROW_W(ROW_W),
    .SETTLE_CYC(SETTLE_CYC), .LOAD_CYC(LOAD_CYC), .DWELL_W(DWELL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] mode;
    int sa, ea, st, dw;
    int n, last, pix, row, probe;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int failures = 0;
  int obs_addr[$];
  int obs_k[$];
  int exp_addr[$];
  int done_k, done_cnt, glitch, busy_err, mon_timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int full_addr();
    return int'({bus.probe, bus.addr, bus.pix});
  endfunction

  task automatic issue(input int m, input int sa, input int ea, input int st, input int dw);
    bus.mode       = 2'(m);
    bus.start_addr = ADDR_W'(sa);
    bus.end_addr   = ADDR_W'(ea);
    bus.stride     = ADDR_W'(st);
    bus.dwell      = DWELL_W'(dw);
    bus.trig       = 1'b1;
    step();
    bus.trig       = 1'b0;
  endtask

  // Expected visit order, straight from the sweep rules.
  task automatic model(input int m, input int sa, input int ea, input int st, input int n_cont);
    int s, a;
    exp_addr.delete();
    s = (st == 0) ? 1 : st;
    a = sa;
    exp_addr.push_back(a);
    if (m == 2) begin
      while ((a + s <= ea) && (a + s < (1 << ADDR_W))) begin
        a = a + s;
        exp_addr.push_back(a);
      end
    end else if (m == 3) begin
      while (exp_addr.size() < n_cont) begin
        a = ((a + s > ea) || (a + s >= (1 << ADDR_W))) ? sa : a + s;
        exp_addr.push_back(a);
      end
    end
  endtask

  // k counts edges since the trigger edge; k0 is the sample already in hand.
  task automatic monitor(input int k0, input int budget, input int stop_after);
    int a, cur, prev_load, last_chg;
    obs_addr.delete();
    obs_k.delete();
    done_k = -1; done_cnt = 0; glitch = 0; busy_err = 0; mon_timeout = 1;
    cur = full_addr(); last_chg = 0; prev_load = 0;
    for (int k = k0; k < k0 + budget; k++) begin
      if (k > k0) step();
      a = full_addr();
      if (a != cur) begin
        cur = a;
        last_chg = k;
        if (bus.load) glitch++;
      end
      if (bus.load && (prev_load == 0)) begin
        obs_addr.push_back(a);
        obs_k.push_back(k);
        if (k - last_chg < SETTLE_CYC) glitch++;
      end
      if (bus.done) begin
        if (done_k < 0) done_k = k;
        done_cnt++;
        if (bus.busy) busy_err++;
      end else if ((bus.state != 3'd0) && !bus.busy) begin
        busy_err++;
      end
      prev_load = int'(bus.load);
      if ((stop_after > 0) && (obs_addr.size() >= stop_after)) begin
        mon_timeout = 0;
        break;
      end
      if (bus.state == 3'd0) begin
        mon_timeout = 0;
        break;
      end
    end
  endtask

  task automatic check_run(input string nm, input int dw, input bit expect_done);
    int p, n;
    p = PER_BASE + dw;
    n = exp_addr.size();
    check({nm, " timeout"}, mon_timeout, 0);
    check({nm, " npoints"}, obs_addr.size(), n);
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      check($sformatf("%s addr%0d", nm, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s when%0d", nm, i), obs_k[i], SETTLE_CYC + i * p);
    end
    if (expect_done) begin
      check({nm, " done_at"}, done_k, SETTLE_CYC + (n - 1) * p + LOAD_CYC);
      check({nm, " done_cnt"}, done_cnt, 1);
    end else begin
      check({nm, " done_cnt"}, done_cnt, 0);
    end
    check({nm, " settle_stable"}, glitch, 0);
    check({nm, " busy"}, busy_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, sa, ea, st, dw, cnt;
    string nm;

    vecs[0] = '{2'd1, 'h2A7, 0, 0, 0, 1, 'h2A7, 3, 'h29, 2};
    vecs[1] = '{2'd2, 0, 15, 4, 3, 4, 12, 0, 0, 0};
    vecs[2] = '{2'd2, 'h3FC, 'h3FF, 2, 0, 2, 'h3FE, 0, 'h3F, 3};
    vecs[3] = '{2'd2, 20, 10, 1, 1, 1, 20, 0, 5, 0};
    vecs[4] = '{2'd2, 8, 11, 0, 2, 4, 11, 0, 2, 0};

    bus.trig = 1'b0; bus.mode = 2'd0; bus.start_addr = '0; bus.end_addr = '0;
    bus.stride = '0; bus.dwell = '0; bus.abort = 1'b0;

    rst = 1'b0;
    repeat (3) step();
    check("reset state", int'(bus.state), 0);
    check("reset load", int'(bus.load), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset addr", full_addr(), 0);
    rst = 1'b1;
    step();
    check("post-reset state", int'(bus.state), 0);

    for (int i = 0; i < 5; i++) begin
      nm = $sformatf("vec%0d", i);
      issue(vecs[i].mode, vecs[i].sa, vecs[i].ea, vecs[i].st, vecs[i].dw);
      check({nm, " pix"}, int'(bus.pix), vecs[i].pix);
      check({nm, " row"}, int'(bus.addr), vecs[i].row);
      check({nm, " probe"}, int'(bus.probe), vecs[i].probe);
      check({nm, " busy0"}, int'(bus.busy), 1);
      check({nm, " state0"}, int'(bus.state), 1);
      model(vecs[i].mode, vecs[i].sa, vecs[i].ea, vecs[i].st, 0);
      monitor(0, SETTLE_CYC + (vecs[i].n + 2) * (PER_BASE + vecs[i].dw) + 20, 0);
      check_run(nm, vecs[i].dw, 1'b1);
      check({nm, " table_n"}, obs_addr.size(), vecs[i].n);
      repeat (3) step();
      check({nm, " held_addr"}, full_addr(), vecs[i].last);
      check({nm, " idle"}, int'(bus.state), 0);
    end

    // Continuous wrap, then abort while load is high.
    issue(3, 5, 7, 1, 0);
    model(3, 5, 7, 1, 5);
    monitor(0, 8 * PER_BASE + 20, 5);
    check_run("cont", 0, 1'b0);
    check("cont in_load", int'(bus.load), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort load", int'(bus.load), 0);
    check("abort state", int'(bus.state), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    cnt = 0;
    for (int k = 0; k < 3 * PER_BASE; k++) begin
      step();
      cnt += int'(bus.done) + int'(bus.load);
    end
    check("abort quiet", cnt, 0);
    check("abort held_addr", full_addr(), 6);

    // A second trigger while busy must not disturb the running sweep.
    issue(2, 0, 15, 4, 3);
    bus.mode = 2'd1; bus.start_addr = 'h155; bus.dwell = '0;
    bus.trig = 1'b1;
    step();
    bus.trig = 1'b0;
    model(2, 0, 15, 4, 0);
    monitor(1, 6 * (PER_BASE + 3) + 20, 0);
    check_run("busy_trig", 3, 1'b1);

    // mode 00 trigger is a no-op.
    bus.mode = 2'd0; bus.start_addr = 'h3AA;
    bus.trig = 1'b1;
    step();
    bus.trig = 1'b0;
    check("nop state", int'(bus.state), 0);
    check("nop busy", int'(bus.busy), 0);
    check("nop addr", full_addr(), 12);

    // Abort during SETTLE.
    issue(2, 'h100, 'h110, 4, 1);
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_settle state", int'(bus.state), 0);
    check("abort_settle busy", int'(bus.busy), 0);
    cnt = 0;
    for (int k = 0; k < 2 * PER_BASE; k++) begin
      step();
      cnt += int'(bus.done) + int'(bus.load);
    end
    check("abort_settle quiet", cnt, 0);
    check("abort_settle addr", full_addr(), 'h100);

    // Reset in the middle of a sweep clears everything.
    issue(3, 'h2A7, 'h2B0, 1, 0);
    repeat (SETTLE_CYC) step();
    check("rst_mid load_before", int'(bus.load), 1);
    rst = 1'b0;
    step();
    check("rst_mid load", int'(bus.load), 0);
    check("rst_mid busy", int'(bus.busy), 0);
    check("rst_mid state", int'(bus.state), 0);
    check("rst_mid addr", full_addr(), 0);
    check("rst_mid done", int'(bus.done), 0);
    rst = 1'b1;
    step();
    check("rst_mid idle", int'(bus.state), 0);

    // Randomized single/range commands.
    for (int it = 0; it < 20; it++) begin
      m  = int'($urandom_range(1, 2));
      sa = (it % 4 == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
      ea = sa + int'($urandom_range(0, 45)) - 5;
      if (ea < 0) ea = 0;
      if (ea > 1023) ea = 1023;
      st = int'($urandom_range(0, 6));
      dw = int'($urandom_range(0, 3));
      nm = $sformatf("rnd%0d", it);
      issue(m, sa, ea, st, dw);
      model(m, sa, ea, st, 0);
      monitor(0, SETTLE_CYC + (exp_addr.size() + 2) * (PER_BASE + dw) + 20, 0);
      check_run(nm, dw, 1'b1);
      repeat (int'($urandom_range(0, 2))) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
